axis_mc_pkt_fifo: RTL and testbench

Multi-channel packetising AXI-Stream master FIFO, the parametrised successor to the single-channel AXI master stream FIFO. Upstream logic writes words into one of NUM_CH per-channel FIFOs; once a channel holds a full packet, a round-robin arbiter drains exactly one packet from it onto a single AXI-Stream master port, with TLAST and TDEST. It sits between a register or DMA write front-end and a downstream AXI-Stream consumer.

---
 rtl/axis_mc_pkt_fifo_pkg.sv | 19 +
 rtl/axis_chan_fifo.sv | 64 ++++++
 rtl/axis_mc_pkt_fifo.sv | 155 +++++++++++++++
 tb/tb_axis_mc_pkt_fifo.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_mc_pkt_fifo_pkg.sv
// rtl/axis_mc_pkt_fifo_pkg.sv - shared types and width helpers for the multi-channel packet FIFO
package axis_mc_pkt_fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    // Channel index width never collapses to zero bits, even for a single channel
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // One extra bit so a full FIFO is distinguishable from an empty one
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_chan_fifo.sv
// rtl/axis_chan_fifo.sv - single-channel FIFO with async-read memory, push/pop/flush
module axis_chan_fifo
    import axis_mc_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_mc_pkt_fifo.sv
// rtl/axis_mc_pkt_fifo.sv - per-channel FIFOs drained one whole packet at a time onto an AXI-Stream master
module axis_mc_pkt_fifo
    import axis_mc_pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = ch_width(NUM_CH),
    localparam int CNT_W     = cnt_width(DEPTH)
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    s_wr_valid,
    output logic                    s_wr_ready,
    input  logic [DATA_WIDTH-1:0]   s_wr_data,
    input  logic [CH_W-1:0]         s_wr_ch,
    input  logic [15:0]             cfg_pkt_len,
    input  logic                    cfg_enable,
    input  logic                    cfg_flush,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [CH_W-1:0]         m_axis_tdest,
    output logic [NUM_CH*CNT_W-1:0] stat_level
);

    state_t                r_state;
    state_t                w_next_state;
    logic [CH_W-1:0]       r_tdest;
    logic [CH_W-1:0]       r_rr_last;
    logic [CNT_W-1:0]      r_len_q;
    logic [CNT_W-1:0]      r_beat;
    logic [CNT_W-1:0]      w_len;
    logic [CH_W-1:0]       w_grant_ch;
    logic                  w_grant_found;
    int                    w_idx;
    logic                  w_ch_ok;
    logic                  w_flush;
    logic                  w_beat_fire;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop;
    logic [NUM_CH-1:0]     w_eligible;
    logic [DATA_WIDTH-1:0] w_head  [NUM_CH];
    logic [CNT_W-1:0]      w_count [NUM_CH];

    always_comb begin
        w_len = CNT_W'(cfg_pkt_len);
        if (cfg_pkt_len == 16'd0) begin
            w_len = CNT_W'(1);
        end else if (cfg_pkt_len > 16'(DEPTH)) begin
            w_len = CNT_W'(DEPTH);
        end
    end

    // Channel codes beyond NUM_CH (non power-of-two counts) stall rather than alias
    if (NUM_CH == (1 << CH_W)) begin : g_ch_all
        assign w_ch_ok = 1'b1;
    end else begin : g_ch_chk
        assign w_ch_ok = (s_wr_ch < CH_W'(NUM_CH));
    end

    assign s_wr_ready  = w_ch_ok && !w_full[s_wr_ch] && !cfg_flush;
    assign w_flush     = cfg_flush && (r_state == ST_IDLE);
    assign w_beat_fire = m_axis_tvalid && m_axis_tready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_push[c]     = s_wr_valid && s_wr_ready && (s_wr_ch == CH_W'(c));
        assign w_pop[c]      = w_beat_fire && (r_tdest == CH_W'(c));
        assign w_eligible[c] = (w_count[c] >= w_len);
        assign stat_level[c*CNT_W +: CNT_W] = w_count[c];

        axis_chan_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .i_clk   (ACLK),
            .i_rst_n (ARESETN),
            .i_push  (w_push[c]),
            .i_data  (s_wr_data),
            .i_pop   (w_pop[c]),
            .i_flush (w_flush),
            .o_head  (w_head[c]),
            .o_full  (w_full[c]),
            .o_count (w_count[c])
        );
    end

    // Scan from furthest to nearest so the nearest eligible channel after rr_last wins
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_ch    = '0;
        w_idx         = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_idx = (int'(r_rr_last) + i) % NUM_CH;
            if (w_eligible[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_ch    = CH_W'(w_idx);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cfg_enable && !cfg_flush && w_grant_found) begin
                    w_next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_beat_fire && m_axis_tlast) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axis_tvalid = (r_state == ST_BURST);
        m_axis_tlast  = m_axis_tvalid && (r_beat == r_len_q - CNT_W'(1));
        m_axis_tdata  = m_axis_tvalid ? w_head[r_tdest] : '0;
        m_axis_tdest  = r_tdest;
    end

    // Packet length and channel are frozen at grant; config changes apply to the next packet
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_tdest   <= '0;
            r_rr_last <= CH_W'(NUM_CH - 1);
            r_len_q   <= '0;
            r_beat    <= '0;
        end else if ((r_state == ST_IDLE) && (w_next_state == ST_BURST)) begin
            r_tdest <= w_grant_ch;
            r_len_q <= w_len;
            r_beat  <= '0;
        end else if (w_beat_fire) begin
            r_beat <= r_beat + CNT_W'(1);
            if (m_axis_tlast) begin
                r_rr_last <= r_tdest;
            end
        end
    end

endmodule

// File: tb/tb_axis_mc_pkt_fifo.sv
// tb/tb_axis_mc_pkt_fifo.sv - self-checking bench for axis_mc_pkt_fifo
module tb_axis_mc_pkt_fifo;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CW     = 5;

    logic                 ACLK;
    logic                 ARESETN;
    logic                 s_wr_valid;
    logic                 s_wr_ready;
    logic [DW-1:0]        s_wr_data;
    logic [CH_W-1:0]      s_wr_ch;
    logic [15:0]          cfg_pkt_len;
    logic                 cfg_enable;
    logic                 cfg_flush;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic [DW-1:0]        m_axis_tdata;
    logic                 m_axis_tlast;
    logic [CH_W-1:0]      m_axis_tdest;
    logic [NUM_CH*CW-1:0] stat_level;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pkt_len;
        int          ch;
        int          exp_len;
    } vec_t;
    vec_t vecs [7];

    logic [DW-1:0] q [NUM_CH][$];

    axis_mc_pkt_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_CH     (NUM_CH)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .s_wr_valid    (s_wr_valid),
        .s_wr_ready    (s_wr_ready),
        .s_wr_data     (s_wr_data),
        .s_wr_ch       (s_wr_ch),
        .cfg_pkt_len   (cfg_pkt_len),
        .cfg_enable    (cfg_enable),
        .cfg_flush     (cfg_flush),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .stat_level    (stat_level)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] lvl(input int c);
        return stat_level[c*CW +: CW];
    endfunction

    task automatic step();
        @(posedge ACLK);
        #2;
    endtask

    task automatic do_reset();
        ARESETN    = 1'b0;
        s_wr_valid = 1'b0;
        repeat (2) step();
        ARESETN = 1'b1;
        step();
    endtask

    task automatic wr(input int ch, input logic [DW-1:0] d);
        int n;
        n = 0;
        s_wr_valid = 1'b1;
        s_wr_ch    = CH_W'(ch);
        s_wr_data  = d;
        #1;
        while (!s_wr_ready && n < 200) begin
            step();
            n++;
        end
        check("wr_accept", s_wr_ready, 1);
        step();
        s_wr_valid = 1'b0;
    endtask

    task automatic wait_valid(input int maxwait);
        int n;
        n = 0;
        while (!m_axis_tvalid && n < maxwait) begin
            step();
            n++;
        end
        check("pkt_start", m_axis_tvalid, 1);
    endtask

    // Assumes tready is held high; data of a packet is base, base+1, ...
    task automatic expect_pkt(input int ch, input int len, input logic [DW-1:0] base, input int maxwait);
        wait_valid(maxwait);
        if (!m_axis_tvalid) return;
        for (int b = 0; b < len; b++) begin
            check("pkt_valid", m_axis_tvalid, 1);
            check("pkt_tdest", m_axis_tdest, ch);
            check("pkt_tdata", m_axis_tdata, base + DW'(b));
            check("pkt_tlast", m_axis_tlast, (b == len - 1));
            step();
        end
        check("pkt_gap", m_axis_tvalid, 0);
    endtask

    task automatic random_round(input int ncyc, input int len);
        logic [NUM_CH*CW-1:0] e;
        int m_busy, m_ch, m_beat, m_rr, pick, c;
        do_reset();
        for (int k = 0; k < NUM_CH; k++) q[k].delete();
        m_busy = 0; m_ch = 0; m_beat = 0; m_rr = NUM_CH - 1;
        cfg_enable  = 1'b1;
        cfg_flush   = 1'b0;
        cfg_pkt_len = 16'(len);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (cyc < ncyc - 300) begin
                s_wr_valid    = ($urandom_range(0, 9) < 6);
                s_wr_ch       = CH_W'($urandom_range(0, NUM_CH - 1));
                s_wr_data     = $urandom;
                m_axis_tready = ($urandom_range(0, 9) < 7);
            end else begin
                s_wr_valid    = 1'b0;
                m_axis_tready = 1'b1;
            end
            #1;
            for (int k = 0; k < NUM_CH; k++) e[k*CW +: CW] = CW'(q[k].size());
            check("rnd_level", stat_level, e);
            check("rnd_ready", s_wr_ready, (q[s_wr_ch].size() < DEPTH));
            check("rnd_tvalid", m_axis_tvalid, m_busy);
            if (m_busy != 0) begin
                check("rnd_tdest", m_axis_tdest, m_ch);
                check("rnd_tlast", m_axis_tlast, (m_beat == len - 1));
                if (q[m_ch].size() > 0) check("rnd_tdata", m_axis_tdata, q[m_ch][0]);
                if (m_axis_tready) begin
                    if (q[m_ch].size() > 0) void'(q[m_ch].pop_front());
                    m_beat++;
                    if (m_beat == len) begin
                        m_busy = 0;
                        m_rr   = m_ch;
                    end
                end
            end else begin
                check("rnd_idle_tdata", m_axis_tdata, 0);
                pick = -1;
                for (int i = NUM_CH; i >= 1; i--) begin
                    c = (m_rr + i) % NUM_CH;
                    if (q[c].size() >= len) pick = c;
                end
                if (pick >= 0) begin
                    m_busy = 1;
                    m_ch   = pick;
                    m_beat = 0;
                end
            end
            if (s_wr_valid && s_wr_ready) q[s_wr_ch].push_back(s_wr_data);
            step();
        end
    endtask

    int b;

    initial begin
        vecs[0] = '{16'd0,     0, 1};
        vecs[1] = '{16'd1,     1, 1};
        vecs[2] = '{16'd3,     2, 3};
        vecs[3] = '{16'd16,    3, 16};
        vecs[4] = '{16'd17,    0, 16};
        vecs[5] = '{16'hFFFF,  1, 16};
        vecs[6] = '{16'd2,     3, 2};

        ARESETN       = 1'b0;
        s_wr_valid    = 1'b0;
        s_wr_data     = '0;
        s_wr_ch       = '0;
        cfg_pkt_len   = 16'd4;
        cfg_enable    = 1'b0;
        cfg_flush     = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) step();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdest", m_axis_tdest, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_level", stat_level, 0);
        check("rst_ready", s_wr_ready, 1);
        ARESETN = 1'b1;
        step();

        // single packet on channel 2, grant latency
        cfg_pkt_len   = 16'd4;
        cfg_enable    = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) wr(2, 32'hA0 + DW'(i));
        check("lat_edge1", m_axis_tvalid, 0);
        step();
        check("lat_edge2", m_axis_tvalid, 1);
        expect_pkt(2, 4, 32'hA0, 0);

        // round-robin between channels 0 and 1
        cfg_enable  = 1'b0;
        cfg_pkt_len = 16'd2;
        for (int i = 0; i < 4; i++) wr(0, 32'h100 + DW'(i));
        for (int i = 0; i < 4; i++) wr(1, 32'h200 + DW'(i));
        cfg_enable = 1'b1;
        expect_pkt(0, 2, 32'h100, 5);
        expect_pkt(1, 2, 32'h200, 1);
        expect_pkt(0, 2, 32'h102, 1);
        expect_pkt(1, 2, 32'h202, 1);

        // full channel stalls writes; the stalled word lands during the drain
        cfg_enable  = 1'b0;
        cfg_pkt_len = 16'd16;
        for (int i = 0; i < 16; i++) wr(3, 32'h300 + DW'(i));
        s_wr_valid = 1'b1;
        s_wr_ch    = 2'd3;
        s_wr_data  = 32'h310;
        #1;
        check("full_ready", s_wr_ready, 0);
        check("full_level", lvl(3), 16);
        step();
        check("full_ready_hold", s_wr_ready, 0);
        cfg_enable = 1'b1;
        fork
            wr(3, 32'h310);
            expect_pkt(3, 16, 32'h300, 5);
        join
        check("refill_level", lvl(3), 1);
        cfg_pkt_len = 16'd1;
        expect_pkt(3, 1, 32'h310, 5);

        // backpressure and mid-packet length change
        cfg_enable    = 1'b0;
        cfg_pkt_len   = 16'd4;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) wr(1, 32'h400 + DW'(i));
        cfg_enable = 1'b1;
        wait_valid(5);
        b = 0;
        for (int k = 0; k < 16 && b < 4; k++) begin
            m_axis_tready = ((k % 2) == 0);
            if (k == 1) cfg_pkt_len = 16'd2;
            #1;
            check("stall_valid", m_axis_tvalid, 1);
            check("stall_tdata", m_axis_tdata, 32'h400 + DW'(b));
            check("stall_tlast", m_axis_tlast, (b == 3));
            if (m_axis_tready) b++;
            step();
        end
        check("stall_beats", b, 4);
        check("stall_gap", m_axis_tvalid, 0);
        check("stall_level", lvl(1), 0);
        m_axis_tready = 1'b1;
        cfg_pkt_len   = 16'd4;

        // flush during a packet waits for tlast
        cfg_enable = 1'b0;
        for (int i = 0; i < 4; i++) wr(0, 32'h500 + DW'(i));
        for (int i = 0; i < 2; i++) wr(1, 32'h600 + DW'(i));
        cfg_enable = 1'b1;
        wait_valid(5);
        check("flush_tdest", m_axis_tdest, 0);
        cfg_flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("flush_valid", m_axis_tvalid, 1);
            check("flush_tdata", m_axis_tdata, 32'h500 + DW'(i));
            check("flush_tlast", m_axis_tlast, (i == 3));
            check("flush_hold", lvl(1), 2);
            step();
        end
        #1;
        check("flush_idle", m_axis_tvalid, 0);
        check("flush_ready", s_wr_ready, 0);
        step();
        check("flush_clear", stat_level, 0);
        cfg_flush = 1'b0;
        repeat (4) step();
        check("flush_no_grant", m_axis_tvalid, 0);
        check("flush_level", stat_level, 0);

        // zero length means one word per packet
        cfg_pkt_len = 16'd0;
        wr(2, 32'h55);
        expect_pkt(2, 1, 32'h55, 5);

        // asynchronous reset mid-packet
        cfg_enable  = 1'b0;
        cfg_pkt_len = 16'd4;
        for (int i = 0; i < 4; i++) wr(0, 32'h700 + DW'(i));
        cfg_enable = 1'b1;
        wait_valid(5);
        step();
        #1;
        ARESETN = 1'b0;
        #1;
        check("arst_tvalid", m_axis_tvalid, 0);
        check("arst_tlast", m_axis_tlast, 0);
        check("arst_tdata", m_axis_tdata, 0);
        check("arst_level", stat_level, 0);
        step();
        ARESETN = 1'b1;
        repeat (3) step();
        check("arst_no_grant", m_axis_tvalid, 0);

        // effective-length table
        do_reset();
        m_axis_tready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cfg_enable  = 1'b0;
            cfg_pkt_len = vecs[k].pkt_len;
            for (int i = 0; i < vecs[k].exp_len; i++)
                wr(vecs[k].ch, 32'h7000 + DW'(k * 256 + i));
            check("tbl_level", lvl(vecs[k].ch), vecs[k].exp_len);
            cfg_enable = 1'b1;
            expect_pkt(vecs[k].ch, vecs[k].exp_len, 32'h7000 + DW'(k * 256), 5);
            check("tbl_drained", lvl(vecs[k].ch), 0);
        end

        random_round(1500, $urandom_range(1, 4));
        random_round(1500, $urandom_range(2, 5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
